// File: rtl/bash_hash_msg_buf.sv
// Message buffer for the bash hash core: collects 64-bit host words into a
// 1024-bit rate block, appends the 0x40 padding byte, and handshakes each
// block with the core control unit through prep/start requests.
module bash_hash_msg_buf (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          init_i,
   input  logic [63:0]   data_i,
   input  logic          valid_i,
   input  logic          last_i,
   input  logic [3:0]    bytes_i,
   output logic          ready_o,
   input  logic          rdy_i,
   input  logic          start_i,
   input  logic          active_i,
   output logic          prep_active_o,
   output logic          start_active_o,
   output logic [1023:0] block_o,
   output logic          final_o,
   output logic          done_o
);

   typedef enum logic [1:0] {IDLE, FILL, FULL, DONE} state_e;

   state_e        state_q, state_d;
   logic [3:0]    idx_q, idx_d;
   logic          padPending_q, padPending_d;
   logic [1023:0] block_q, block_d;
   logic          final_q, final_d;
   logic          prep_q, prep_d;
   logic [3:0]    lastBytes;
   logic [63:0]   lastWord;

   assign lastBytes = (bytes_i > 4'd8) ? 4'd8 : bytes_i;

   // Build the final word: keep the valid bytes, drop 0x40 right after them, zero the rest
   always_comb begin
      lastWord = '0;
      for (int b = 0; b < 8; b++) begin
         if (b < int'(lastBytes)) begin
            lastWord[8*b +: 8] = data_i[8*b +: 8];
         end else if (b == int'(lastBytes)) begin
            lastWord[8*b +: 8] = 8'h40;
         end
      end
   end

   // Next-state logic; init_i overrides everything else in the same cycle
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      padPending_d = padPending_q;
      block_d      = block_q;
      final_d      = final_q;
      prep_d       = 1'b0;
      if (init_i) begin
         prep_d       = 1'b1;
         block_d      = '0;
         idx_d        = 4'd0;
         padPending_d = 1'b0;
         final_d      = 1'b0;
         state_d      = FILL;
      end else begin
         case (state_q)
            IDLE: begin
            end
            FILL: begin
               if (valid_i) begin
                  if (last_i) begin
                     block_d[{idx_q, 6'd0} +: 64] = lastWord;
                     state_d = FULL;
                     if (lastBytes != 4'd8) begin
                        final_d = 1'b1;
                     end else if (idx_q != 4'd15) begin
                        block_d[{idx_q + 4'd1, 6'd0} +: 64] = 64'h40;
                        final_d = 1'b1;
                     end else begin
                        padPending_d = 1'b1;
                        final_d      = 1'b0;
                     end
                  end else begin
                     block_d[{idx_q, 6'd0} +: 64] = data_i;
                     if (idx_q == 4'd15) begin
                        state_d = FULL;
                        final_d = 1'b0;
                     end else begin
                        idx_d = idx_q + 4'd1;
                     end
                  end
               end
            end
            FULL: begin
               if (start_i) begin
                  block_d = '0;
                  idx_d   = 4'd0;
                  if (padPending_q) begin
                     block_d[7:0] = 8'h40;
                     padPending_d = 1'b0;
                     final_d      = 1'b1;
                  end else if (final_q) begin
                     state_d = DONE;
                  end else begin
                     state_d = FILL;
                  end
               end
            end
            DONE: begin
               if (!active_i && rdy_i) begin
                  final_d = 1'b0;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         idx_q        <= 4'd0;
         padPending_q <= 1'b0;
         block_q      <= '0;
         final_q      <= 1'b0;
         prep_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         padPending_q <= padPending_d;
         block_q      <= block_d;
         final_q      <= final_d;
         prep_q       <= prep_d;
      end
   end

   assign ready_o        = (state_q == FILL);
   assign start_active_o = (state_q == FULL) && rdy_i;
   assign done_o         = (state_q == DONE) && !init_i && !active_i && rdy_i;
   assign prep_active_o  = prep_q;
   assign block_o        = block_q;
   assign final_o        = final_q;

endmodule

// File: doc/bash_hash_msg_buf.md
BASH_HASH_MSG_BUF -- requirements
Module: bash_hash_msg_buf

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high; ports named clk_i and rst_i.
REQ-002 clk_i  in  1  system clock, all state on rising edge.
REQ-003 rst_i  in  1  async active-high reset.
REQ-004 init_i  in  1  host pulse: begin new message, aborts any message in progress.
REQ-005 data_i  in  64  message word; byte n = data_i[8n+7:8n].
REQ-006 valid_i  in  1  data_i valid.
REQ-007 last_i  in  1  data_i is final message word.
REQ-008 bytes_i  in  4  valid bytes in last word, 0..8; sampled only with last_i; values >8 treated as 8.
REQ-009 ready_o  out  1  buffer accepts a word this cycle.
REQ-010 rdy_i  in  1  core control unit can take prep/start (control unit rdy output).
REQ-011 start_i  in  1  control unit start pulse; current block is absorbed.
REQ-012 active_i  in  1  control unit permutation running.
REQ-013 prep_active_o  out  1  request to control unit: initialise state.
REQ-014 start_active_o  out  1  request to control unit: block_o ready to absorb.
REQ-015 block_o  out  1024  rate block; word w at block_o[64w+63:64w].
REQ-016 final_o  out  1  block_o holds the last padded block.
REQ-017 done_o  out  1  one-cycle pulse: final block fully processed.

Function
REQ-018 SHALL implement states IDLE, FILL, FULL, DONE, plus a 4-bit word index idx and a pad_pending flag.
REQ-019 IDLE: ready_o=0; init_i -> prep_active_o=1 for exactly one cycle, block_o cleared, idx=0, next FILL.
REQ-020 FILL: ready_o=1; valid_i&ready_o writes word idx; visible on block_o next cycle; idx increments.
REQ-021 Last word with bytes_i=k<8: bytes 0..k-1 from data_i, byte k = 0x40, bytes k+1..7 = 0; next FULL, final_o=1.
REQ-022 Last word with k=8 and idx<15: word written whole, byte 0 of word idx+1 = 0x40; next FULL, final_o=1.
REQ-023 Last word with k=8 and idx=15: word written whole, pad_pending=1; next FULL, final_o=0.
REQ-024 Non-last word at idx=15: next FULL, final_o=0.
REQ-025 Words not written in a block SHALL read zero.
REQ-026 FULL: ready_o=0; start_active_o = rdy_i (combinational), 0 otherwise.
REQ-027 FULL with start_i: block_o cleared, idx=0; if pad_pending, byte 0 = 0x40, pad_pending=0, final_o=1, stay FULL; else if final_o, next DONE; else next FILL.
REQ-028 start_i outside FULL SHALL be ignored.
REQ-029 DONE: ready_o=0; when active_i=0 and rdy_i=1, done_o=1 one cycle, final_o cleared, next IDLE.
REQ-030 init_i in FILL, FULL or DONE: same action as REQ-019 (abort, clear, prep pulse, FILL); init_i has priority over valid_i and start_i in the same cycle.
REQ-031 prep_active_o SHALL assert only in the cycle after init_i was sampled, independent of rdy_i.
REQ-032 valid_i while ready_o=0 SHALL be ignored; no word lost when ready_o=1.

Reset
REQ-033 rst_i=1 SHALL immediately force IDLE, idx=0, pad_pending=0, block_o=0, ready_o=0, prep_active_o=0, start_active_o=0, final_o=0, done_o=0.
REQ-034 Reset mid-message SHALL discard the message; the next init_i starts cleanly.

Verification
REQ-035 init, one last word 0x0000000000636261 bytes_i=3 -> block_o[63:0]=0x0000000040636261, rest 0, final_o=1, start_active_o=1 when rdy_i=1.
REQ-036 init, 16 full words, no last -> FULL final_o=0; start_i -> FILL, idx=0, block_o=0, ready_o=1.
REQ-037 init, 16 words, 16th with last, bytes_i=8 -> start_i -> block_o[7:0]=0x40, rest 0, final_o=1; second start_i -> DONE; active_i=0, rdy_i=1 -> done_o one-cycle pulse.
REQ-038 init, last word bytes_i=0 at idx=0 -> block_o[7:0]=0x40, rest 0, final_o=1 (empty message).
REQ-039 FULL with rdy_i=0 -> start_active_o=0; init_i and start_i same cycle -> prep_active_o pulse, FILL, block_o=0.
REQ-040 rst_i asserted mid-FILL between clock edges -> all outputs 0 without waiting for clk_i.
